// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the machine word and the fetch sequencer
// state encoding, plus small helpers used by the fetch path.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } lc3b_fetch_state;

  // Instructions are two bytes wide, so the sequential PC advances by 2.
  localparam lc3b_word PC_STEP = 16'd2;

  // Memory is word addressed on even byte addresses; bit 0 is dropped.
  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Watchdog for the fetch memory handshake. Counts cycles spent waiting for
// mem_resp and flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_count;

  // Count waiting cycles; a clear on entry to a new wait restarts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (run && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The first waiting cycle sees a count of 0, so the last allowed one sees
  // TIMEOUT_CYCLES-1.
  assign expired = run && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer feeding the IR register. Accepts a fetch
// request, owns the mem_read/mem_resp handshake, and returns the instruction
// word with one-cycle ir_load/pc_load/fetch_done pulses and pc_next = PC+2.
// Optional mem_resp watchdog: define FETCH_TIMEOUT_EN to enable it; without
// it the unit waits indefinitely and fetch_err stays 0.
module fetch_unit
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic [15:0] pc_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic [15:0] ir_data,
  output logic        ir_load,
  output logic [15:0] pc_next,
  output logic        pc_load,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  lc3b_fetch_state r_state;
  lc3b_fetch_state w_state_next;

  lc3b_word r_pc_cap;
  lc3b_word r_ir_data;
  lc3b_word r_pc_next;
  logic     r_fetch_err;

  logic w_capture;
  logic w_commit;
  logic w_timeout;
  logic w_timer_expired;

`ifdef FETCH_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_run;

  // Restart the watchdog whenever a new wait (REQ or DRAIN) begins.
  assign w_timer_clear = ((w_state_next == REQ) || (w_state_next == DRAIN)) &&
                         (w_state_next != r_state);
  assign w_timer_run   = (r_state == REQ) || (r_state == DRAIN);

  fetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clear),
    .run     (w_timer_run),
    .expired (w_timer_expired)
  );
`else
  assign w_timer_expired = 1'b0;
`endif

  // State register; a synchronous reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the strobes that steer the datapath registers.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (fetch_req && !flush) begin
          w_capture    = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          // A flush coinciding with the response discards the data outright;
          // otherwise the outstanding access must still be drained.
          w_state_next = mem_resp ? IDLE : DRAIN;
        end else if (mem_resp) begin
          w_commit     = 1'b1;
          w_state_next = LOAD;
        end else if (w_timer_expired) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      DRAIN: begin
        if (mem_resp) begin
          w_state_next = IDLE;
        end else if (w_timer_expired) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      LOAD: begin
        // Result is already committed, so a flush here has nothing to abort.
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // PC capture, instruction and next-PC registers; they hold between fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_cap    <= '0;
      r_ir_data   <= '0;
      r_pc_next   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_pc_cap <= pc_in;
      end
      if (w_commit) begin
        r_ir_data <= mem_rdata;
        r_pc_next <= r_pc_cap + PC_STEP;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign mem_address = word_align(r_pc_cap);
  assign mem_read    = (r_state == REQ) || (r_state == DRAIN);
  assign ir_data     = r_ir_data;
  assign ir_load     = (r_state == LOAD);
  assign pc_load     = (r_state == LOAD);
  assign fetch_done  = (r_state == LOAD);
  assign pc_next     = r_pc_next;
  assign busy        = (r_state != IDLE);
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model of the fetch sequencer.
module tb_fetch_unit;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        flush;
  logic [15:0] pc_in;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [15:0] ir_data;
  logic        ir_load;
  logic [15:0] pc_next;
  logic        pc_load;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_unit #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .flush       (flush),
    .pc_in       (pc_in),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .ir_data     (ir_data),
    .ir_load     (ir_load),
    .pc_next     (pc_next),
    .pc_load     (pc_load),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks whether a fetch is outstanding, whether it was flushed, and
  // whether a result is being delivered this cycle.
  bit          m_valid = 0;
  bit          m_wait  = 0;
  bit          m_drop  = 0;
  bit          m_load  = 0;
  bit          m_err   = 0;
  int          m_cnt   = 0;
  logic [15:0] m_pc    = '0;
  logic [15:0] m_ir    = '0;
  logic [15:0] m_pcn   = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_wait  = 0;
      m_drop  = 0;
      m_load  = 0;
      m_err   = 0;
      m_cnt   = 0;
      m_pc    = '0;
      m_ir    = '0;
      m_pcn   = '0;
    end else if (m_load) begin
      m_load = 0;
    end else if (m_wait) begin
      if (mem_resp) begin
        if (!(flush || m_drop)) begin
          m_ir   = mem_rdata;
          m_pcn  = m_pc + 16'd2;
          m_load = 1;
        end
        m_wait = 0;
      end else if (flush && !m_drop) begin
        m_drop = 1;
        m_cnt  = 0;
      end else begin
        m_cnt++;
`ifdef FETCH_TIMEOUT_EN
        if (m_cnt == TO) begin
          m_err  = 1;
          m_wait = 0;
        end
`endif
      end
    end else if (fetch_req && !flush) begin
      m_pc   = pc_in;
      m_wait = 1;
      m_drop = 0;
      m_cnt  = 0;
    end
  end

  // Compare every cycle on the falling edge, once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("mem_read",    {15'd0, mem_read},   {15'd0, m_wait});
      check("mem_address", mem_address,         {m_pc[15:1], 1'b0});
      check("ir_data",     ir_data,             m_ir);
      check("pc_next",     pc_next,             m_pcn);
      check("ir_load",     {15'd0, ir_load},    {15'd0, m_load});
      check("pc_load",     {15'd0, pc_load},    {15'd0, m_load});
      check("fetch_done",  {15'd0, fetch_done}, {15'd0, m_load});
      check("busy",        {15'd0, busy},       {15'd0, m_wait || m_load});
      check("fetch_err",   {15'd0, fetch_err},  {15'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch, answer after wait_n REQ cycles; returns in the LOAD cycle.
  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] data, input int wait_n);
    fetch_req = 1'b1;
    pc_in     = pc;
    cyc();
    fetch_req = 1'b0;
    repeat (wait_n) cyc();
    mem_resp  = 1'b1;
    mem_rdata = data;
    cyc();
    mem_resp  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    fetch_req = 1'b0;
    flush     = 1'b0;
    pc_in     = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_busy",     {15'd0, busy}, 16'd0);
    check("rst_ir_data",  ir_data,       16'h0000);
    check("rst_pc_next",  pc_next,       16'h0000);
    check("rst_mem_read", {15'd0, mem_read}, 16'd0);

    // 1: basic fetch, response two cycles after acceptance
    fetch_req = 1'b1;
    pc_in     = 16'h3000;
    cyc();
    fetch_req = 1'b0;
    check("t1_mem_read", {15'd0, mem_read}, 16'd1);
    check("t1_addr",     mem_address,       16'h3000);
    cyc();
    mem_resp  = 1'b1;
    mem_rdata = 16'h1261;
    cyc();
    mem_resp  = 1'b0;
    check("t1_ir_load", {15'd0, ir_load},    16'd1);
    check("t1_done",    {15'd0, fetch_done}, 16'd1);
    check("t1_ir_data", ir_data,             16'h1261);
    check("t1_pc_next", pc_next,             16'h3002);
    cyc();
    check("t1_pulse_end", {15'd0, ir_load}, 16'd0);
    check("t1_idle",      {15'd0, busy},    16'd0);

    // 2: odd PC is word-aligned for memory but pc_next uses the raw PC; wrap
    do_fetch(16'h3001, 16'hABCD, 0);
    check("t2_addr",    mem_address, 16'h3000);
    check("t2_pc_next", pc_next,     16'h3003);
    cyc();
    do_fetch(16'hFFFE, 16'h0F0F, 1);
    check("t2_wrap", pc_next, 16'h0000);
    cyc();

    // 3: flush one cycle after acceptance, memory answers three cycles later
    fetch_req = 1'b1;
    pc_in     = 16'h4000;
    cyc();
    fetch_req = 1'b0;
    flush     = 1'b1;
    cyc();
    flush = 1'b0;
    check("t3_drain_read", {15'd0, mem_read}, 16'd1);
    cyc();
    mem_resp  = 1'b1;
    mem_rdata = 16'hDEAD;
    cyc();
    mem_resp = 1'b0;
    check("t3_idle",    {15'd0, busy},    16'd0);
    check("t3_no_load", {15'd0, ir_load}, 16'd0);
    check("t3_ir_keep", ir_data,          16'h0F0F);

    // 4: flush and response together; then a clean fetch
    fetch_req = 1'b1;
    pc_in     = 16'h5000;
    cyc();
    fetch_req = 1'b0;
    flush     = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 16'hBEEF;
    cyc();
    flush    = 1'b0;
    mem_resp = 1'b0;
    check("t4_idle",    {15'd0, busy},    16'd0);
    check("t4_no_load", {15'd0, ir_load}, 16'd0);
    do_fetch(16'h5002, 16'h2222, 2);
    check("t4_ir_data", ir_data, 16'h2222);
    check("t4_pc_next", pc_next, 16'h5004);
    cyc();

    // 5: reset during REQ, late response ignored
    fetch_req = 1'b1;
    pc_in     = 16'h6000;
    cyc();
    fetch_req = 1'b0;
    reset     = 1'b1;
    cyc();
    reset = 1'b0;
    check("t5_mem_read", {15'd0, mem_read}, 16'd0);
    check("t5_addr",     mem_address,       16'h0000);
    check("t5_ir_data",  ir_data,           16'h0000);
    mem_resp  = 1'b1;
    mem_rdata = 16'h7777;
    cyc();
    mem_resp = 1'b0;
    check("t5_no_load", {15'd0, ir_load}, 16'd0);
    check("t5_busy",    {15'd0, busy},    16'd0);

`ifdef FETCH_TIMEOUT_EN
    // 6: watchdog expiry after TO waiting cycles; error is sticky
    fetch_req = 1'b1;
    pc_in     = 16'h7000;
    cyc();
    fetch_req = 1'b0;
    repeat (TO - 1) cyc();
    check("t6_still_wait", {15'd0, mem_read},  16'd1);
    check("t6_no_err_yet", {15'd0, fetch_err}, 16'd0);
    cyc();
    check("t6_err",      {15'd0, fetch_err}, 16'd1);
    check("t6_read_off", {15'd0, mem_read},  16'd0);
    do_fetch(16'h7100, 16'h3333, 1);
    check("t6_sticky", {15'd0, fetch_err}, 16'd1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_err_clr", {15'd0, fetch_err}, 16'd0);
`endif

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(99) == 0);
      fetch_req = 1'($urandom_range(1));
      flush     = ($urandom_range(19) == 0);
      mem_resp  = ($urandom_range(3) == 0);
      pc_in     = 16'($urandom);
      mem_rdata = 16'($urandom);
      cyc();
    end
    reset     = 1'b0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    mem_resp  = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
